// File: rtl/cnn_pkg.sv
// ============================================================================
// cnn_pkg : fixed-point widths, saturation limits and accumulator state codes
// Rev 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int NUM_WIDTH = 16;
    localparam int NUM_POINT = 8;
    localparam int ACC_WIDTH = 32;

    localparam logic signed [NUM_WIDTH-1:0] NUM_MAX = {1'b0, {(NUM_WIDTH-1){1'b1}}};
    localparam logic signed [NUM_WIDTH-1:0] NUM_MIN = {1'b1, {(NUM_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/num_sat.sv
// ============================================================================
// num_sat : optional ReLU followed by signed saturation from IN_WIDTH to OUT_WIDTH
// Rev 1.0
// ============================================================================
`default_nettype none

module num_sat #(
    parameter int IN_WIDTH  = cnn_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH = cnn_pkg::NUM_WIDTH
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    input  logic                        relu_en,
    output logic signed [OUT_WIDTH-1:0] dout
);

    localparam logic signed [OUT_WIDTH-1:0] C_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] C_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // The value fits only when every bit from the output sign bit upward agrees.
    logic [IN_WIDTH-OUT_WIDTH:0] w_upper;
    logic                        w_neg;

    assign w_upper = din[IN_WIDTH-1:OUT_WIDTH-1];
    assign w_neg   = din[IN_WIDTH-1];

    always_comb begin
        dout = din[OUT_WIDTH-1:0];
        if (relu_en && w_neg) begin
            dout = '0;
        end else if (!w_neg && (|w_upper)) begin
            dout = C_MAX;
        end else if (w_neg && !(&w_upper)) begin
            dout = C_MIN;
        end
    end

endmodule

`default_nettype wire

// File: rtl/kernel_accum.sv
// ============================================================================
// kernel_accum : per-window accumulate + bias, optional ReLU, saturate, valid/ready out
// Rev 1.0
// ============================================================================
`default_nettype none

module kernel_accum #(
    parameter int NUM_WIDTH = cnn_pkg::NUM_WIDTH,
    parameter int ACC_WIDTH = cnn_pkg::ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        up_val,
    input  logic                        up_last,
    input  logic signed [NUM_WIDTH-1:0] up_data,
    output logic                        up_rdy,
    input  logic signed [NUM_WIDTH-1:0] bias,
    input  logic                        relu_en,
    output logic                        dn_val,
    input  logic                        dn_rdy,
    output logic signed [NUM_WIDTH-1:0] dn_data,
    output logic                        err
);

    import cnn_pkg::*;

    acc_state_t                  r_state;
    logic signed [ACC_WIDTH-1:0] r_acc;

    logic                        w_accept;
    logic signed [ACC_WIDTH-1:0] w_data_ext;
    logic signed [ACC_WIDTH-1:0] w_bias_ext;
    logic signed [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [NUM_WIDTH-1:0] w_result;

    // Every beat is gated, so a new result can never overwrite an unconsumed one.
    assign up_rdy   = !dn_val || dn_rdy;
    assign w_accept = up_val && up_rdy;

    assign w_data_ext = {{(ACC_WIDTH-NUM_WIDTH){up_data[NUM_WIDTH-1]}}, up_data};
    assign w_bias_ext = {{(ACC_WIDTH-NUM_WIDTH){bias[NUM_WIDTH-1]}}, bias};

    // The first beat of a window starts from the bias instead of the stale accumulator.
    assign w_base = (r_state == ACC_IDLE) ? w_bias_ext : r_acc;
    assign w_sum  = w_base + w_data_ext;

    num_sat #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (NUM_WIDTH)
    ) u_num_sat (
        .din     (w_sum),
        .relu_en (relu_en),
        .dout    (w_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC_IDLE;
            r_acc   <= '0;
            dn_val  <= 1'b0;
            dn_data <= '0;
            err     <= 1'b0;
        end else begin
            if (up_val && !up_rdy) begin
                err <= 1'b1;
            end

            if (dn_val && dn_rdy) begin
                dn_val <= 1'b0;
            end

            // A load in the same cycle as a drain takes priority over the clear above.
            if (w_accept) begin
                r_acc <= w_sum;
                if (up_last) begin
                    dn_val  <= 1'b1;
                    dn_data <= w_result;
                    r_state <= ACC_IDLE;
                end else begin
                    r_state <= ACC_RUN;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_kernel_accum.sv
// ============================================================================
// tb_kernel_accum : directed Q8.8 checks plus a short randomized window run
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_kernel_accum;

    logic        clk;
    logic        rst_n;
    logic        up_val;
    logic        up_last;
    logic [15:0] up_data;
    logic        up_rdy;
    logic [15:0] bias;
    logic        relu_en;
    logic        dn_val;
    logic        dn_rdy;
    logic [15:0] dn_data;
    logic        err;

    int vectors    = 0;
    int miscompares = 0;

    kernel_accum dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .up_val  (up_val),
        .up_last (up_last),
        .up_data (up_data),
        .up_rdy  (up_rdy),
        .bias    (bias),
        .relu_en (relu_en),
        .dn_val  (dn_val),
        .dn_rdy  (dn_rdy),
        .dn_data (dn_data),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one beat for exactly one rising edge; returns 1 time unit after that edge.
    task automatic beat(input logic [15:0] d, input logic l);
        up_val  = 1'b1;
        up_data = d;
        up_last = l;
        @(posedge clk);
        #1;
        up_val  = 1'b0;
        up_last = 1'b0;
    endtask

    function automatic logic [15:0] ref_sat(input longint s_in, input logic r);
        longint s;
        logic [15:0] res;
        s = s_in;
        if (r && s < 0) s = 0;
        if (s > 32767)       res = 16'h7FFF;
        else if (s < -32768) res = 16'h8000;
        else                 res = s[15:0];
        return res;
    endfunction

    logic [15:0] exp_q[$];
    longint      model;
    int          beats_left;
    int          wins;
    int          budget;
    logic [15:0] head;

    initial begin
        rst_n   = 1'b0;
        up_val  = 1'b0;
        up_last = 1'b0;
        up_data = '0;
        bias    = '0;
        relu_en = 1'b0;
        dn_rdy  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_dn_val",  {31'd0, dn_val}, 32'd0);
        check("rst_dn_data", {16'd0, dn_data}, 32'd0);
        check("rst_err",     {31'd0, err}, 32'd0);
        check("rst_up_rdy",  {31'd0, up_rdy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: 0.5 + 10 + 26 + 42 + 58 = 136.5 -> saturates high
        bias = 16'h0080;
        beat(16'h0A00, 1'b0);
        beat(16'h1A00, 1'b0);
        beat(16'h2A00, 1'b0);
        check("t1_no_early_val", {31'd0, dn_val}, 32'd0);
        beat(16'h3A00, 1'b1);
        check("t1_dn_val",  {31'd0, dn_val}, 32'd1);
        check("t1_dn_data", {16'd0, dn_data}, 32'h7FFF);

        // 2: 10 + 26 = 36.0, then a back-to-back single-beat window of 1.0
        bias = 16'h0000;
        beat(16'h0A00, 1'b0);
        check("t2_drained", {31'd0, dn_val}, 32'd0);
        beat(16'h1A00, 1'b1);
        check("t2_sum36", {16'd0, dn_data}, 32'h2400);
        beat(16'h0100, 1'b1);
        check("t2_single_val",  {31'd0, dn_val}, 32'd1);
        check("t2_single_data", {16'd0, dn_data}, 32'h0100);
        @(posedge clk);
        #1;
        check("t2_idle_val", {31'd0, dn_val}, 32'd0);

        // 3: -3.0 + 1.0 with and without ReLU, plus saturation edges
        relu_en = 1'b1;
        beat(16'hFD00, 1'b0);
        beat(16'h0100, 1'b1);
        check("t3_relu_on", {16'd0, dn_data}, 32'h0000);
        relu_en = 1'b0;
        beat(16'hFD00, 1'b0);
        beat(16'h0100, 1'b1);
        check("t3_relu_off", {16'd0, dn_data}, 32'hFE00);
        bias = 16'h8000;
        beat(16'h8000, 1'b1);
        check("t3_sat_min", {16'd0, dn_data}, 32'h8000);
        bias = 16'h7F00;
        beat(16'h00FF, 1'b1);
        check("t3_exact_max", {16'd0, dn_data}, 32'h7FFF);

        // 4: stall the consumer, drop a violating beat, confirm the next window is clean
        bias = 16'h0000;
        beat(16'h0100, 1'b0);
        beat(16'h0200, 1'b1);
        dn_rdy = 1'b0;
        #1;
        check("t4_up_rdy_low", {31'd0, up_rdy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        up_val  = 1'b1;
        up_data = 16'h7000;
        up_last = 1'b1;
        @(posedge clk);
        #1;
        up_val  = 1'b0;
        up_last = 1'b0;
        check("t4_err_set", {31'd0, err}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("t4_held_val",  {31'd0, dn_val}, 32'd1);
        check("t4_held_data", {16'd0, dn_data}, 32'h0300);
        dn_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("t4_drain", {31'd0, dn_val}, 32'd0);
        beat(16'h0500, 1'b0);
        beat(16'h0100, 1'b1);
        check("t4_next_sum",  {16'd0, dn_data}, 32'h0600);
        check("t4_err_sticky", {31'd0, err}, 32'd1);

        // 5: reset in the middle of a window
        bias = 16'h0100;
        beat(16'h0100, 1'b0);
        beat(16'h0100, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_dn_val",  {31'd0, dn_val}, 32'd0);
        check("t5_rst_dn_data", {16'd0, dn_data}, 32'd0);
        check("t5_rst_err",     {31'd0, err}, 32'd0);
        check("t5_rst_up_rdy",  {31'd0, up_rdy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bias = 16'h0200;
        beat(16'h0100, 1'b0);
        beat(16'h0100, 1'b1);
        check("t5_clean_sum", {16'd0, dn_data}, 32'h0400);
        @(posedge clk);
        #1;

        // 6: random windows of 1..16 beats against a saturating model
        beats_left = 0;
        wins       = 0;
        budget     = 0;
        model      = 0;
        while ((wins < 30 || beats_left != 0) && budget < 3000) begin
            budget++;
            dn_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (dn_val && dn_rdy) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL rand_extra: observed result %h expected none pending", dn_data);
                end else begin
                    head = exp_q.pop_front();
                    check("rand_result", {16'd0, dn_data}, {16'd0, head});
                end
            end
            if (beats_left == 0 && wins < 30) begin
                beats_left = $urandom_range(1, 16);
                bias       = 16'($urandom);
                model      = longint'($signed(bias));
                wins++;
            end
            if (beats_left > 0 && up_rdy && ($urandom_range(0, 3) != 0)) begin
                up_val  = 1'b1;
                up_data = 16'($urandom);
                up_last = (beats_left == 1);
                model   = model + longint'($signed(up_data));
                if (beats_left == 1) begin
                    relu_en = 1'($urandom_range(0, 1));
                    exp_q.push_back(ref_sat(model, relu_en));
                end
                beats_left--;
            end else begin
                up_val  = 1'b0;
                up_last = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        up_val  = 1'b0;
        up_last = 1'b0;
        check("rand_completed", {31'd0, (budget < 3000)}, 32'd1);
        dn_rdy = 1'b1;
        #1;
        if (dn_val) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL rand_extra: observed result %h expected none pending", dn_data);
            end else begin
                head = exp_q.pop_front();
                check("rand_last_result", {16'd0, dn_data}, {16'd0, head});
            end
        end
        @(posedge clk);
        #1;
        check("rand_drained_val", {31'd0, dn_val}, 32'd0);
        check("rand_no_loss", exp_q.size(), 32'd0);
        check("rand_no_err", {31'd0, err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/kernel_accum.md
# kernel_accum

Accumulates the stream of per-cycle partial sums produced by `group_add` across one kernel window, adds a per-window bias, optionally applies ReLU, and saturates the result back to `NUM_WIDTH` fixed point. It sits directly downstream of `group_add` and presents one result per window on a valid/ready handshake to the write-back stage. Back-pressure is exported to the upstream controller as `up_rdy`, because `group_add` itself cannot stall.

## Interface
- `NUM_WIDTH`, 16: width of signed fixed-point input, bias and output.
- `NUM_POINT`, 8: fractional bits. Identical for input, bias and output, so no shifting is needed.
- `ACC_WIDTH`, 32: internal accumulator width. Must be ≥ `NUM_WIDTH`+8.

- `clk` in 1: single clock, all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `up_val` in 1: `up_data` carries a valid partial sum this cycle.
- `up_last` in 1: qualifies `up_val`; this beat closes the window.
- `up_data` in `NUM_WIDTH`: signed partial sum (the `group_add` `dn_data`).
- `up_rdy` out 1: block can accept a beat this cycle.
- `bias` in `NUM_WIDTH`: signed bias, sampled on the first beat of a window.
- `relu_en` in 1: clamp negative results to 0; sampled on the last beat.
- `dn_val` out 1: `dn_data` holds a finished result.
- `dn_rdy` in 1: consumer accepts the result.
- `dn_data` out `NUM_WIDTH`: signed saturated result.
- `err` out 1: sticky protocol error, set when `up_val` is high while `up_rdy` is low.

## Operation
- State machine has two states.
  - IDLE: no window open.
  - ACCUM: window open.
- Beat accepted means `up_val & up_rdy`.
- IDLE:
  - Accepted beat with `up_last`=0: `acc` ← sext(`bias`) + sext(`up_data`); go to ACCUM.
  - Accepted beat with `up_last`=1: single-beat window; result formed directly and the state stays IDLE.
- ACCUM:
  - Accepted beat: `acc` ← `acc` + sext(`up_data`).
  - If that beat has `up_last`=1: result formed; go to IDLE.
- Result formation, applied to the final sum S in `ACC_WIDTH`:
  - If `relu_en` and S<0, S ← 0.
  - Then saturate: S > 2^(NUM_WIDTH-1)-1 gives 0x7FFF-style max; S < -2^(NUM_WIDTH-1) gives min.
  - The output register loads the result and `dn_val` is set.
- The accumulator itself wraps modulo 2^`ACC_WIDTH`. It is not saturated; `ACC_WIDTH` is sized so wrap cannot occur for supported window lengths.
- Output register:
  - `dn_val` clears on `dn_val & dn_rdy` unless a new result loads in the same cycle, in which case it stays 1 with the new data.
  - `dn_data` is stable while `dn_val & !dn_rdy`.
- `up_rdy` = !`dn_val` | `dn_rdy` (combinational). Non-last beats are also gated, which keeps the rule simple for the controller.
- Violation (`up_val` & !`up_rdy`):
  - The beat is dropped: `acc` and state are unchanged.
  - `err` is set and stays set until reset.
- Reset mid-window discards the partial `acc` and any pending result.

## Timing
- Reset values: `dn_val`=0, `dn_data`=0, `err`=0, state=IDLE, `acc`=0. `up_rdy`=1 out of reset.
- Latency: last beat accepted at edge N gives `dn_val`=1 and valid `dn_data` after edge N, i.e. visible in cycle N+1.
- Throughput: one beat per cycle. Back-to-back windows need no bubble, including repeated single-beat windows while `dn_rdy`=1.
- Same cycle: drain of the old result and load of a new result both happen; the new data wins.
- `err` asserts the cycle after the violating cycle.

## Structure
- Shared package `cnn_pkg`: fixed-point width constants (`NUM_WIDTH`, `NUM_POINT`), state encoding `ACC_IDLE`/`ACC_RUN`, saturation min/max localparams.
- One natural sub-module: `num_sat`, a combinational ReLU plus saturate from `ACC_WIDTH` to `NUM_WIDTH`. It is reusable by other stages.
- Accumulator, FSM and output register live in `kernel_accum`.

## Test plan
Values are Q8.8.
1. Bias 0.5 (0x0080); beats 10, 26, 42, 58 with last on the 4th; `dn_rdy`=1. Sum 136.5 saturates → `dn_data`=0x7FFF one cycle after the last beat.
2. Bias 0; beats 10, 26 with last on the 2nd → `dn_data`=0x2400 (36.0). An immediately following single-beat window of 1.0 with bias 0 → next cycle `dn_data`=0x0100.
3. Bias 0; beats -3.0, 1.0 with last, `relu_en`=1 → 0x0000. Same beats with `relu_en`=0 → 0xFE00.
4. Result pending with `dn_rdy`=0 for 5 cycles → `up_rdy`=0 and `dn_data` stable. Drive `up_val` during the stall → `err`=1 and the next window's sum is unaffected by the dropped beat.
5. Pull `rst_n` low in the middle of a 4-beat window → all outputs return to reset values immediately. The next window after release starts clean from bias.
6. Randomized windows of 1–16 beats with random `dn_rdy` → results match a saturating reference model, with no loss or duplication.
